// File: rtl/dmem_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_if
// Brief    : Data-memory request/response channel between the core's
//            load/store path (master) and a memory responder (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [3:0]      req_be;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Word-organised data SRAM answering single load/store requests
//            after a fixed number of wait states, with error reporting.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic  clk,
    input  logic  areset_n,
    dmem_if.slave bus
);
    localparam int         c_IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [2:0] c_WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_cnt;
    logic [2:0]        w_cnt_nxt;
    logic              w_access;

    logic              r_we;
    logic [XLEN-1:2]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [3:0]        r_be;

    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [XLEN-1:0]   r_rsp_rdata;
    logic              r_rsp_err;

    logic [XLEN-1:0]   r_mem [DEPTH_WORDS];

    logic              w_accept;
    logic              w_acc_we;
    logic [XLEN-1:2]   w_acc_addr;
    logic [XLEN-1:0]   w_acc_wdata;
    logic [3:0]        w_acc_be;
    logic [c_IDX_W-1:0] w_idx;
    logic              w_oob;
    logic              w_be_legal;
    logic              w_err;
    logic              w_mem_we;
    logic              w_unused_addr_lsb;

    assign w_unused_addr_lsb = &{1'b0, bus.req_addr[1:0]};

    assign w_accept = (r_state == S_IDLE) && r_req_ready && bus.req_valid;

    // With zero wait states the access happens on the accept edge itself,
    // before the request has been latched, so the live inputs are used.
    assign w_acc_we    = (r_state == S_IDLE) ? bus.req_we              : r_we;
    assign w_acc_addr  = (r_state == S_IDLE) ? bus.req_addr[XLEN-1:2]  : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? bus.req_wdata           : r_wdata;
    assign w_acc_be    = (r_state == S_IDLE) ? bus.req_be              : r_be;

    assign w_idx = w_acc_addr[c_IDX_W+1:2];
    assign w_oob = |w_acc_addr[XLEN-1:c_IDX_W+2];

    always_comb begin
        w_be_legal = 1'b0;
        case (w_acc_be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: w_be_legal = 1'b1;
            default:                   w_be_legal = 1'b0;
        endcase
    end

    assign w_err    = w_oob | (w_acc_we & ~w_be_legal);
    assign w_mem_we = w_access & w_acc_we & ~w_err;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_access    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (WAIT_STATES == 0) begin
                        w_state_nxt = S_RESP;
                        w_access    = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = c_WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = S_RESP;
                    w_access    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= 4'd0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_ready <= (w_state_nxt == S_IDLE);
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_addr  <= bus.req_addr[XLEN-1:2];
                r_wdata <= bus.req_wdata;
                r_be    <= bus.req_be;
            end
            if (w_access) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_err || w_acc_we) ? '0 : r_mem[w_idx];
            end else if ((r_state == S_RESP) && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // Storage is deliberately left without reset so it maps onto SRAM.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Self-checking bench for dmem_responder at WAIT_STATES 1/0/3/7.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        areset_n = 1'b0;
    int          sel = 0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_ready = 1'b0;
    logic        obs_req_ready, obs_rsp_valid, obs_err;
    logic [31:0] obs_rdata;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          ws_of [4] = '{1, 0, 3, 7};

    logic [31:0] mdl_mem [4][1024];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_if #(.XLEN(32)) if_ws1 ();
    dmem_if #(.XLEN(32)) if_ws0 ();
    dmem_if #(.XLEN(32)) if_ws3 ();
    dmem_if #(.XLEN(32)) if_ws7 ();

    assign if_ws1.req_valid = req_valid && (sel == 0);
    assign if_ws0.req_valid = req_valid && (sel == 1);
    assign if_ws3.req_valid = req_valid && (sel == 2);
    assign if_ws7.req_valid = req_valid && (sel == 3);
    assign if_ws1.req_we = req_we;    assign if_ws0.req_we = req_we;
    assign if_ws3.req_we = req_we;    assign if_ws7.req_we = req_we;
    assign if_ws1.req_addr = req_addr;  assign if_ws0.req_addr = req_addr;
    assign if_ws3.req_addr = req_addr;  assign if_ws7.req_addr = req_addr;
    assign if_ws1.req_wdata = req_wdata;  assign if_ws0.req_wdata = req_wdata;
    assign if_ws3.req_wdata = req_wdata;  assign if_ws7.req_wdata = req_wdata;
    assign if_ws1.req_be = req_be;    assign if_ws0.req_be = req_be;
    assign if_ws3.req_be = req_be;    assign if_ws7.req_be = req_be;
    assign if_ws1.rsp_ready = rsp_ready;  assign if_ws0.rsp_ready = rsp_ready;
    assign if_ws3.rsp_ready = rsp_ready;  assign if_ws7.rsp_ready = rsp_ready;

    dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(1)) u_ws1 (.clk(clk), .areset_n(areset_n), .bus(if_ws1));
    dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(0)) u_ws0 (.clk(clk), .areset_n(areset_n), .bus(if_ws0));
    dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(3)) u_ws3 (.clk(clk), .areset_n(areset_n), .bus(if_ws3));
    dmem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(7)) u_ws7 (.clk(clk), .areset_n(areset_n), .bus(if_ws7));

    always_comb begin
        obs_req_ready = if_ws1.req_ready; obs_rsp_valid = if_ws1.rsp_valid;
        obs_rdata     = if_ws1.rsp_rdata; obs_err       = if_ws1.rsp_err;
        case (sel)
            1: begin obs_req_ready = if_ws0.req_ready; obs_rsp_valid = if_ws0.rsp_valid;
                     obs_rdata = if_ws0.rsp_rdata; obs_err = if_ws0.rsp_err; end
            2: begin obs_req_ready = if_ws3.req_ready; obs_rsp_valid = if_ws3.rsp_valid;
                     obs_rdata = if_ws3.rsp_rdata; obs_err = if_ws3.rsp_err; end
            3: begin obs_req_ready = if_ws7.req_ready; obs_rsp_valid = if_ws7.rsp_valid;
                     obs_rdata = if_ws7.rsp_rdata; obs_err = if_ws7.rsp_err; end
            default: ;
        endcase
    end

    // Reference: word memory with byte-lane merge and the legal-enable list.
    task automatic model_txn(input int d, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             output logic [31:0] exp_rdata, output bit exp_err);
        int unsigned word = addr / 4;
        bit legal = (be == 4'b0001) || (be == 4'b0010) || (be == 4'b0100) || (be == 4'b1000) ||
                    (be == 4'b0011) || (be == 4'b1100) || (be == 4'b1111);
        exp_err   = (word >= 1024) || (we && !legal);
        exp_rdata = 32'h0;
        if (!exp_err) begin
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) mdl_mem[d][word][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                exp_rdata = mdl_mem[d][word];
            end
        end
    endtask

    // Drives one request from a negedge; returns what the DUT did. Ends on a negedge.
    task automatic run_txn(input int d, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, input int stall,
                           output int lat, output logic [31:0] rdata, output bit err,
                           output bit ready_low, output bit stable, output bit ready_back,
                           output int acc_cyc);
        sel = d;
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        req_valid = 1'b1; rsp_ready = (stall == 0);
        lat = 0; ready_low = 1'b1; stable = 1'b1; acc_cyc = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) begin
                acc_cyc = cyc;
                req_valid = 1'b0;
                req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
            end
            if (obs_req_ready) ready_low = 1'b0;
        end while (!obs_rsp_valid && lat < 40);
        rdata = obs_rdata;
        err   = obs_err;
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = ~wdata; req_be = 4'hF;
            @(posedge clk);
            @(negedge clk);
            if (!obs_rsp_valid || obs_rdata !== rdata || obs_err !== err || obs_req_ready) stable = 1'b0;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready_back = obs_req_ready && !obs_rsp_valid;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 4; d++) begin
            sel = d; #1;
            checks++;
            if ({obs_req_ready, obs_rsp_valid, obs_err, obs_rdata} !== 35'd0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got ready=%b valid=%b err=%b rdata=%h, expected all zero",
                         d, obs_req_ready, obs_rsp_valid, obs_err, obs_rdata);
            end
        end
        @(negedge clk); areset_n = 1'b1;
        @(negedge clk); @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            sel = d; #1;
            checks++;
            if (obs_req_ready !== 1'b1 || obs_rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_release dut%0d: got ready=%b valid=%b, expected ready=1 valid=0",
                         d, obs_req_ready, obs_rsp_valid);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_store_load();
        int lat, acc; logic [31:0] rd, erd; bit er, eer, rl, st, rb;
        model_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, erd, eer);
        run_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, lat, rd, er, rl, st, rb, acc);
        checks++; if (lat !== 2) begin errors++; $display("FAIL store_latency: got %0d, expected 2", lat); end
        checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL store_rsp: got err=%b rdata=%h, expected err=0 rdata=0", er, rd); end
        model_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
        run_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, lat, rd, er, rl, st, rb, acc);
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL load_deadbeef: got err=%b rdata=%h, expected err=0 rdata=deadbeef", er, rd); end
    endtask

    task automatic test_byte_lanes();
        int lat, acc; logic [31:0] rd, erd; bit er, eer, rl, st, rb;
        model_txn(0, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, erd, eer);
        run_txn(0, 1'b1, 32'h10, 32'h0000AA00, 4'b0010, 0, lat, rd, er, rl, st, rb, acc);
        model_txn(0, 1'b1, 32'h10, 32'h12340000, 4'b1100, erd, eer);
        run_txn(0, 1'b1, 32'h10, 32'h12340000, 4'b1100, 0, lat, rd, er, rl, st, rb, acc);
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL half_store_err: got %b, expected 0", er); end
        model_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
        run_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, lat, rd, er, rl, st, rb, acc);
        checks++; if (rd !== 32'h1234AAEF || rd !== erd) begin errors++; $display("FAIL lane_merge: got %h, expected 1234aaef", rd); end
        run_txn(0, 1'b0, 32'h13, 32'h0, 4'h0, 0, lat, rd, er, rl, st, rb, acc);
        checks++; if (rd !== 32'h1234AAEF || er !== 1'b0) begin errors++; $display("FAIL unaligned_load: got err=%b rdata=%h, expected err=0 rdata=1234aaef", er, rd); end
    endtask

    task automatic test_errors();
        int lat, acc; logic [31:0] rd, erd; bit er, eer, rl, st, rb;
        model_txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, erd, eer);
        run_txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, lat, rd, er, rl, st, rb, acc);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL oob_load: got err=%b rdata=%h, expected err=1 rdata=0", er, rd); end
        model_txn(0, 1'b1, 32'h20, 32'h11111111, 4'hF, erd, eer);
        run_txn(0, 1'b1, 32'h20, 32'h11111111, 4'hF, 0, lat, rd, er, rl, st, rb, acc);
        model_txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0101, erd, eer);
        run_txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0101, 0, lat, rd, er, rl, st, rb, acc);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL be0101_store: got err=%b rdata=%h, expected err=1 rdata=0", er, rd); end
        model_txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, erd, eer);
        run_txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, lat, rd, er, rl, st, rb, acc);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL be0000_store: got err=%b, expected 1", er); end
        run_txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, lat, rd, er, rl, st, rb, acc);
        checks++; if (rd !== 32'h11111111 || er !== 1'b0) begin errors++; $display("FAIL err_no_write: got err=%b rdata=%h, expected err=0 rdata=11111111", er, rd); end
    endtask

    task automatic test_latency_sweep();
        int lat, acc1, acc2; logic [31:0] rd, erd, wd; bit er, eer, rl, st, rb;
        for (int d = 0; d < 4; d++) begin
            wd = $urandom;
            model_txn(d, 1'b1, 32'h80, wd, 4'hF, erd, eer);
            run_txn(d, 1'b1, 32'h80, wd, 4'hF, 0, lat, rd, er, rl, st, rb, acc1);
            checks++; if (lat !== 1 + ws_of[d]) begin errors++; $display("FAIL latency ws=%0d: got %0d, expected %0d", ws_of[d], lat, 1 + ws_of[d]); end
            checks++; if (!rl || !rb) begin errors++; $display("FAIL ready_window ws=%0d: got low=%b back=%b, expected 1 1", ws_of[d], rl, rb); end
            model_txn(d, 1'b0, 32'h80, 32'h0, 4'h0, erd, eer);
            run_txn(d, 1'b0, 32'h80, 32'h0, 4'h0, 0, lat, rd, er, rl, st, rb, acc2);
            checks++; if (acc2 - acc1 !== 2 + ws_of[d]) begin errors++; $display("FAIL back_to_back ws=%0d: got spacing %0d, expected %0d", ws_of[d], acc2 - acc1, 2 + ws_of[d]); end
            checks++; if (rd !== erd || er !== eer) begin errors++; $display("FAIL sweep_load ws=%0d: got %h/%b, expected %h/%b", ws_of[d], rd, er, erd, eer); end
        end
    endtask

    task automatic test_backpressure();
        int lat, acc; logic [31:0] rd, erd; bit er, eer, rl, st, rb;
        model_txn(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, erd, eer);
        run_txn(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 0, lat, rd, er, rl, st, rb, acc);
        model_txn(0, 1'b0, 32'h30, 32'h0, 4'h0, erd, eer);
        run_txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 5, lat, rd, er, rl, st, rb, acc);
        checks++; if (!st) begin errors++; $display("FAIL stall_stable: got stable=%b, expected 1", st); end
        checks++; if (!rb || !rl) begin errors++; $display("FAIL stall_release: got back=%b low=%b, expected 1 1", rb, rl); end
        checks++; if (rd !== erd) begin errors++; $display("FAIL stall_data: got %h, expected %h", rd, erd); end
        run_txn(0, 1'b0, 32'h30, 32'h0, 4'h0, 0, lat, rd, er, rl, st, rb, acc);
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL stall_no_accept: got %h, expected cafef00d", rd); end
    endtask

    task automatic test_random();
        int lat, acc, stall; logic [31:0] rd, erd, wd, ad; logic [3:0] be; bit we, er, eer, rl, st, rb;
        logic [3:0] legal [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        for (int d = 0; d < 4; d++) begin
            for (int w = 0; w < 16; w++) begin
                wd = $urandom;
                model_txn(d, 1'b1, 32'h100 + 4 * w, wd, 4'hF, erd, eer);
                run_txn(d, 1'b1, 32'h100 + 4 * w, wd, 4'hF, 0, lat, rd, er, rl, st, rb, acc);
            end
            for (int n = 0; n < 40; n++) begin
                we = 1'($urandom);
                wd = $urandom;
                stall = $urandom_range(0, 3);
                ad = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0000_1000)
                                                 : 32'h100 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
                be = ($urandom_range(0, 2) != 0) ? legal[$urandom_range(0, 6)] : 4'($urandom);
                model_txn(d, we, ad, wd, be, erd, eer);
                run_txn(d, we, ad, wd, be, stall, lat, rd, er, rl, st, rb, acc);
                checks++;
                if (rd !== erd || er !== eer || lat !== 1 + ws_of[d] || !rl || !st || !rb) begin
                    errors++;
                    $display("FAIL random ws=%0d we=%b addr=%h be=%b: got rdata=%h err=%b lat=%0d flags=%b%b%b, expected rdata=%h err=%b lat=%0d flags=111",
                             ws_of[d], we, ad, be, rd, er, lat, rl, st, rb, erd, eer, 1 + ws_of[d]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, acc, k; logic [31:0] rd, erd; bit er, eer, rl, st, rb;
        model_txn(2, 1'b1, 32'h40, 32'h0, 4'hF, erd, eer);
        run_txn(2, 1'b1, 32'h40, 32'h0, 4'hF, 0, lat, rd, er, rl, st, rb, acc);
        sel = 2; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h55555555; req_be = 4'hF;
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); @(negedge clk); req_valid = 1'b0;
        @(posedge clk); #1 areset_n = 1'b0; #1;
        checks++;
        if ({obs_req_ready, obs_rsp_valid, obs_err, obs_rdata} !== 35'd0) begin
            errors++; $display("FAIL async_reset_wait: got ready=%b valid=%b err=%b rdata=%h, expected all zero",
                               obs_req_ready, obs_rsp_valid, obs_err, obs_rdata);
        end
        @(negedge clk); @(negedge clk); areset_n = 1'b1;
        @(negedge clk); @(negedge clk);
        model_txn(2, 1'b0, 32'h40, 32'h0, 4'h0, erd, eer);
        run_txn(2, 1'b0, 32'h40, 32'h0, 4'h0, 0, lat, rd, er, rl, st, rb, acc);
        checks++; if (rd !== 32'h0 || rd !== erd) begin errors++; $display("FAIL dropped_store: got %h, expected 00000000", rd); end
        // A store that has reached the response phase is already in memory.
        req_we = 1'b1; req_addr = 32'h44; req_wdata = 32'h77777777; req_be = 4'hF;
        req_valid = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); @(negedge clk); req_valid = 1'b0;
        k = 0;
        while (!obs_rsp_valid && k < 40) begin @(negedge clk); k++; end
        checks++; if (!obs_rsp_valid) begin errors++; $display("FAIL committed_wait: got rsp_valid=0, expected 1 within 40 cycles"); end
        areset_n = 1'b0; #1;
        checks++; if (obs_rsp_valid !== 1'b0 || obs_req_ready !== 1'b0) begin errors++; $display("FAIL async_reset_resp: got valid=%b ready=%b, expected 0 0", obs_rsp_valid, obs_req_ready); end
        model_txn(2, 1'b1, 32'h44, 32'h77777777, 4'hF, erd, eer);
        @(negedge clk); @(negedge clk); areset_n = 1'b1; rsp_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        model_txn(2, 1'b0, 32'h44, 32'h0, 4'h0, erd, eer);
        run_txn(2, 1'b0, 32'h44, 32'h0, 4'h0, 0, lat, rd, er, rl, st, rb, acc);
        checks++; if (rd !== 32'h77777777 || rd !== erd) begin errors++; $display("FAIL committed_store: got %h, expected 77777777", rd); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_store_load();
        test_byte_lanes();
        test_errors();
        test_latency_sweep();
        test_backpressure();
        test_random();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the rv32i core. It accepts single load/store requests from the core's load/store path over a valid/ready request channel. It services them from an internal word-organised SRAM after a programmable number of wait states, and returns read data or a completion with error status over a valid/ready response channel. It is the slave end of the core's data interface and replaces the zero-latency memory stub so that core stall logic can be exercised.

## Interface
- XLEN, 32, data and address width
- DEPTH_WORDS, 1024, memory depth in 32-bit words (power of two)
- WAIT_STATES, 1, cycles between request acceptance and the memory access (0..7)

- clk  in  1  system clock, rising edge
- areset_n  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  XLEN  byte address; bits [1:0] ignored
- req_wdata  in  XLEN  store data, lane-aligned
- req_be  in  4  store byte enables, bit n = byte lane n
- rsp_valid  out  1  response present
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  XLEN  load data (full word)
- rsp_err  out  1  request faulted

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid & req_ready, latch we/addr/wdata/be.
  - If WAIT_STATES=0, go to RESP.
  - Otherwise load wait counter with WAIT_STATES-1 and go to WAIT.
- WAIT: req_ready=0. The counter decrements each cycle. At 0, go to RESP.
- Memory access occurs on the transition into RESP, in one edge:
  - Store: write lanes with be=1; other lanes are unchanged.
  - Load: capture mem[word] into rsp_rdata.
- RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_valid & rsp_ready, then go to IDLE.
- Error (rsp_err=1, no memory write, rsp_rdata=0) is raised when either:
  - the word index addr[XLEN-1:2] >= DEPTH_WORDS, or
  - it is a store with be not in {0001,0010,0100,1000,0011,1100,1111}. This includes 0000.
- req_be is ignored for loads. Loads always return the full word.
- rsp_rdata for stores is 0.
- Memory array is not reset. Contents are undefined until written.
- Request inputs are ignored outside IDLE.

## Timing
- Reset values: req_ready=0 while areset_n=0, then 1 (IDLE). rsp_valid=0, rsp_rdata=0, rsp_err=0. FSM=IDLE, counter=0.
- Request accepted at edge T. Then rsp_valid=1 from edge T+1+WAIT_STATES.
- req_ready deasserts from edge T+1 and reasserts on the edge after the response handshake.
- Minimum request-to-request spacing is 2+WAIT_STATES cycles when rsp_ready is held high.
- rsp_ready low in RESP stalls indefinitely with no output change. No further request is accepted.
- Reset asserted mid-operation:
  - Immediately returns to IDLE with all outputs at reset values.
  - A store still in WAIT is dropped.
  - A store already committed (in RESP) remains in memory.
- Outputs are registered. No combinational path from req_* or rsp_ready to any output.

## Test plan
- Store/load, WAIT_STATES=1:
  - Store addr=0x10, wdata=0xDEADBEEF, be=1111, accepted at T -> rsp_valid at T+2, err=0.
  - Then load 0x10 -> rsp_rdata=0xDEADBEEF, err=0.
- Byte/half lanes:
  - Over 0xDEADBEEF at 0x10, store be=0010 wdata=0x0000AA00, then be=1100 wdata=0x12340000.
  - Load 0x10 -> 0x1234AAEF. Load 0x13 also -> 0x1234AAEF (addr[1:0] ignored).
- Errors, DEPTH_WORDS=1024:
  - Load 0x1000 -> err=1, rdata=0.
  - Store be=0101 to 0x20 over prior 0x11111111 -> err=1, then load 0x20 returns 0x11111111.
- Latency sweep, WAIT_STATES in {0,3,7}:
  - rsp_valid exactly at T+1+WAIT_STATES.
  - req_ready=0 throughout and returns one cycle after the handshake.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err are stable, req_ready=0, and a new req_valid is not accepted. Release -> IDLE next cycle.
- Reset mid-WAIT, WAIT_STATES=3:
  - Store 0x55555555 to 0x40 over 0x0.
  - Assert areset_n=0 one cycle after acceptance -> outputs reset asynchronously.
  - After release, load 0x40 -> 0x00000000.
